// File: rtl/calculator_seq_pkg.sv
// Shared constants for the sequential calculator: function codes, FSM state
// encoding and a ceiling-log2 helper used to size shift and counter fields.
package calculator_seq_pkg;

   // Function codes presented on func and latched into fn at start.
   localparam logic [2:0] FN_ADD = 3'd0;
   localparam logic [2:0] FN_SUB = 3'd1;
   localparam logic [2:0] FN_AND = 3'd2;
   localparam logic [2:0] FN_OR  = 3'd3;
   localparam logic [2:0] FN_XOR = 3'd4;
   localparam logic [2:0] FN_SHL = 3'd5;
   localparam logic [2:0] FN_MUL = 3'd6;
   localparam logic [2:0] FN_DIV = 3'd7;

   // FSM state encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ALU  = 2'd1;
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Smallest r such that 2**r >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/calculator_seq_if.sv
// Operand/result bundle between the requester (board or bench) and the
// calculator core. The raw button travels with the operands it launches.
interface calculator_seq_if #(
   parameter int WIDTH = 8
);
   logic                 button;
   logic [2:0]           func;
   logic [WIDTH-1:0]     num1;
   logic [WIDTH-1:0]     num2;
   logic [2*WIDTH-1:0]   cal_result;
   logic                 busy;
   logic                 done;
   logic                 err;

   modport master (
      output button, func, num1, num2,
      input  cal_result, busy, done, err
   );

   modport slave (
      input  button, func, num1, num2,
      output cal_result, busy, done, err
   );
endinterface

// File: rtl/calculator_seq_btn_edge.sv
// Push-button front end: synchronises the asynchronous button into clk_g and
// emits a one-cycle start pulse on each synchronised rising edge. A held
// button therefore yields exactly one pulse.
module btn_edge #(
   parameter int SYNC_STG = 2
) (
   input  logic clk_g,
   input  logic rst,
   input  logic button,
   output logic start
);
   logic [SYNC_STG-1:0] sync_r;
   logic                prev_r;
   logic                start_r;

   // Synchroniser chain, previous-level flop and registered edge pulse.
   always_ff @(posedge clk_g) begin
      if (rst) begin
         sync_r  <= '0;
         prev_r  <= 1'b0;
         start_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[SYNC_STG-2:0], button};
         prev_r  <= sync_r[SYNC_STG-1];
         start_r <= sync_r[SYNC_STG-1] & ~prev_r;
      end
   end

   assign start = start_r;
endmodule

// File: rtl/calculator_seq.sv
// Multi-cycle calculator core. Single-cycle ALU ops run through the ALU state;
// multiply (shift-add) and divide (restoring) iterate WIDTH cycles in ITER
// sharing one 2*WIDTH accumulator. Divide by zero short-cuts through ALU.
module calculator_seq
   import calculator_seq_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SYNC_STG = 2
) (
   input  logic            clk_g,
   input  logic            rst,
   calculator_seq_if.slave bus
);
   localparam int RES_W = 2 * WIDTH;
   localparam int SH_W  = clog2(WIDTH) + 1;
   localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   logic [1:0]       state_r;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opb_r;
   logic [2:0]       fn_r;
   logic [RES_W-1:0] acc_r;
   logic [RES_W-1:0] cal_result_r;
   logic [CNT_W-1:0] cnt_r;
   logic             err_r;

   logic             start_s;
   logic             iter_go_s;
   logic [RES_W-1:0] alu_res_s;
   logic [RES_W-1:0] iter_next_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH:0]   psum_s;
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH:0]   trial_s;
   logic [SH_W-1:0]  sh_s;

   btn_edge #(
      .SYNC_STG (SYNC_STG)
   ) u_btn (
      .clk_g  (clk_g),
      .rst    (rst),
      .button (bus.button),
      .start  (start_s)
   );

   // Multiply and non-zero divide need the iterative path; all else is one ALU cycle.
   assign iter_go_s = (bus.func == FN_MUL) || ((bus.func == FN_DIV) && (bus.num2 != '0));

   // Single-cycle ALU result from the latched operands. SUB keeps the borrow
   // as a sign bit so the true signed difference is sign-extended.
   always_comb begin
      sum_s     = {1'b0, opa_r} + {1'b0, opb_r};
      diff_s    = {1'b0, opa_r} - {1'b0, opb_r};
      sh_s      = opb_r[SH_W-1:0];
      alu_res_s = '0;
      case (fn_r)
         FN_ADD:  alu_res_s = {{(WIDTH-1){1'b0}}, sum_s};
         FN_SUB:  alu_res_s = {{(WIDTH-1){diff_s[WIDTH]}}, diff_s};
         FN_AND:  alu_res_s = {{WIDTH{1'b0}}, opa_r & opb_r};
         FN_OR:   alu_res_s = {{WIDTH{1'b0}}, opa_r | opb_r};
         FN_XOR:  alu_res_s = {{WIDTH{1'b0}}, opa_r ^ opb_r};
         FN_SHL:  alu_res_s = {{WIDTH{1'b0}}, opa_r} << sh_s;
         FN_DIV:  alu_res_s = '1;
         default: alu_res_s = '0;
      endcase
   end

   // One iteration step. MUL: acc = {partial product, remaining multiplier bits},
   // add A to the upper half when the LSB is set, then shift right.
   // DIV: acc = {remainder, dividend/quotient}, shift left and try to subtract B.
   always_comb begin
      psum_s   = {1'b0, acc_r[RES_W-1:WIDTH]} + (acc_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
      rem_sh_s = {acc_r[RES_W-1:WIDTH], acc_r[WIDTH-1]};
      trial_s  = rem_sh_s - {1'b0, opb_r};
      if (fn_r == FN_MUL) begin
         iter_next_s = {psum_s, acc_r[WIDTH-1:1]};
      end else if (!trial_s[WIDTH]) begin
         iter_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         iter_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Control FSM plus operand, accumulator, counter, result and error registers.
   always_ff @(posedge clk_g) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         opa_r        <= '0;
         opb_r        <= '0;
         fn_r         <= FN_ADD;
         acc_r        <= '0;
         cnt_r        <= '0;
         cal_result_r <= '0;
         err_r        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  opa_r <= bus.num1;
                  opb_r <= bus.num2;
                  fn_r  <= bus.func;
                  err_r <= 1'b0;
                  if (iter_go_s) begin
                     state_r <= ST_ITER;
                     cnt_r   <= CNT_W'(WIDTH - 1);
                     acc_r   <= (bus.func == FN_MUL) ? {{WIDTH{1'b0}}, bus.num2}
                                                     : {{WIDTH{1'b0}}, bus.num1};
                  end else begin
                     state_r <= ST_ALU;
                  end
               end
            end
            ST_ALU: begin
               cal_result_r <= alu_res_s;
               err_r        <= (fn_r == FN_DIV);
               state_r      <= ST_DONE;
            end
            ST_ITER: begin
               acc_r <= iter_next_s;
               cnt_r <= cnt_r - CNT_W'(1);
               if (cnt_r == '0) begin
                  cal_result_r <= iter_next_s;
                  state_r      <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cal_result = cal_result_r;
   assign bus.busy       = (state_r == ST_ALU) || (state_r == ST_ITER);
   assign bus.done       = (state_r == ST_DONE);
   assign bus.err        = err_r;
endmodule

// File: tb/tb_calculator_seq.sv
// Self-checking bench for calculator_seq: an 8-bit instance for most scenarios
// and a 16-bit instance for the wide multiply. Expected values come from a
// plain-arithmetic reference model of the function table.
module tb_calculator_seq;
   logic clk_g;
   logic rst;
   int   errors;
   int   checks;

   calculator_seq_if #(.WIDTH(8))  bus8 ();
   calculator_seq_if #(.WIDTH(16)) bus16 ();

   calculator_seq #(.WIDTH(8),  .SYNC_STG(2)) dut8  (.clk_g(clk_g), .rst(rst), .bus(bus8));
   calculator_seq #(.WIDTH(16), .SYNC_STG(3)) dut16 (.clk_g(clk_g), .rst(rst), .bus(bus16));

   initial clk_g = 1'b0;
   always #5 clk_g = ~clk_g;

   // Reference model: result, error flag and cycles from first busy to done.
   function automatic void model8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output logic e, output int lat);
      int ia, ib, sh;
      ia = int'(a); ib = int'(b); e = 1'b0; lat = 1; r = 16'h0000;
      case (f)
         3'd0: r = 16'(ia + ib);
         3'd1: r = 16'(ia - ib);
         3'd2: r = 16'(ia & ib);
         3'd3: r = 16'(ia | ib);
         3'd4: r = 16'(ia ^ ib);
         3'd5: begin sh = ib % 16; r = (sh >= 16) ? 16'h0000 : 16'(ia * (1 << sh)); end
         3'd6: begin r = 16'(ia * ib); lat = 8; end
         3'd7: begin
            if (ib == 0) begin r = 16'hFFFF; e = 1'b1; end
            else begin r = 16'((ia % ib) * 256 + ia / ib); lat = 8; end
         end
         default: r = 16'h0000;
      endcase
   endfunction

   // Launch one op on the 8-bit DUT, scramble inputs once busy, capture at done.
   task automatic run_op8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output logic e, output int lat,
                          output logic done_next, output logic timeout);
      int   n;
      logic got;
      timeout = 1'b0; res = 16'h0000; e = 1'b0; lat = 0; done_next = 1'b0; got = 1'b0;
      @(posedge clk_g); #1;
      bus8.func = f; bus8.num1 = a; bus8.num2 = b; bus8.button = 1'b1;
      n = 0;
      while (!bus8.busy && n < 12) begin @(negedge clk_g); n++; end
      if (!bus8.busy) begin
         timeout = 1'b1;
      end else begin
         bus8.func = 3'($urandom); bus8.num1 = 8'($urandom); bus8.num2 = 8'($urandom);
         n = 0;
         while (!got && n < 40) begin
            @(negedge clk_g); n++;
            if (bus8.done) begin got = 1'b1; res = bus8.cal_result; e = bus8.err; lat = n; end
         end
         if (!got) timeout = 1'b1;
         else begin @(negedge clk_g); done_next = bus8.done; end
      end
      bus8.button = 1'b0;
      repeat (5) @(negedge clk_g);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk_g);
      checks += 5;
      if (bus8.cal_result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", bus8.cal_result); end
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus8.busy); end
      if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus8.done); end
      if (bus8.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus8.err); end
      if (bus16.cal_result !== 32'h0) begin errors++; $display("FAIL reset_result16: got %h expected 0", bus16.cal_result); end
      @(posedge clk_g); #1; rst = 1'b0;
      repeat (2) @(negedge clk_g);
   endtask

   task automatic test_directed();
      logic [2:0]  fv [5];
      logic [7:0]  av [5];
      logic [7:0]  bv [5];
      logic [15:0] rv [5];
      logic        ev [5];
      int          lv [5];
      logic [15:0] res;
      logic        e, dn, to;
      int          lat;
      fv = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd7};
      av = '{8'hFF, 8'h03, 8'hFF, 8'd200, 8'd77};
      bv = '{8'h01, 8'h05, 8'hFF, 8'd7, 8'd0};
      rv = '{16'h0100, 16'hFFFE, 16'hFE01, 16'h041C, 16'hFFFF};
      ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      lv = '{1, 1, 8, 8, 1};
      for (int i = 0; i < 5; i++) begin
         run_op8(fv[i], av[i], bv[i], res, e, lat, dn, to);
         checks += 5;
         if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_timeout: got %b expected 0", i, to); end
         if (res !== rv[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, rv[i]); end
         if (e !== ev[i]) begin errors++; $display("FAIL dir%0d_err: got %b expected %b", i, e, ev[i]); end
         if (lat !== lv[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, lv[i]); end
         if (dn !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width: got %b expected 0", i, dn); end
      end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [7:0]  a, b;
      logic [15:0] res, er;
      logic        e, ee, dn, to;
      int          lat, el;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = 8'($urandom); b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) b = 8'h00;
         model8(f, a, b, er, ee, el);
         run_op8(f, a, b, res, e, lat, dn, to);
         checks += 4;
         if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got %b expected 0", i, to); end
         if (res !== er) begin errors++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, er); end
         if (e !== ee) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", i, e, ee); end
         if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el); end
      end
   endtask

   task automatic test_err_sticky();
      logic [15:0] res;
      logic        e, dn, to;
      int          lat;
      run_op8(3'd7, 8'h55, 8'h00, res, e, lat, dn, to);
      repeat (3) @(negedge clk_g);
      checks += 4;
      if (bus8.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus8.err); end
      if (bus8.cal_result !== 16'hFFFF) begin errors++; $display("FAIL result_hold: got %h expected FFFF", bus8.cal_result); end
      run_op8(3'd0, 8'h01, 8'h02, res, e, lat, dn, to);
      if (e !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", e); end
      if (res !== 16'h0003) begin errors++; $display("FAIL after_err_result: got %h expected 0003", res); end
   endtask

   task automatic test_press_during_mul();
      int   n;
      logic seen;
      @(posedge clk_g); #1;
      bus8.func = 3'd6; bus8.num1 = 8'hFF; bus8.num2 = 8'hFF; bus8.button = 1'b1;
      n = 0;
      while (!bus8.busy && n < 12) begin @(negedge clk_g); n++; end
      checks += 1;
      if (!bus8.busy) begin errors++; $display("FAIL mul2_start: got busy=0 expected 1"); end
      bus8.button = 1'b0;
      repeat (2) @(negedge clk_g);
      bus8.button = 1'b1;
      n = 2;
      while (!bus8.done && n < 40) begin @(negedge clk_g); n++; end
      checks += 3;
      if (n !== 8) begin errors++; $display("FAIL mul2_latency: got %0d expected 8", n); end
      if (bus8.cal_result !== 16'hFE01) begin errors++; $display("FAIL mul2_result: got %h expected FE01", bus8.cal_result); end
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin @(negedge clk_g); if (bus8.busy) seen = 1'b1; end
      if (seen !== 1'b0) begin errors++; $display("FAIL mul2_second_press_dropped: got busy=%b expected 0", seen); end
      bus8.button = 1'b0;
      repeat (5) @(negedge clk_g);
   endtask

   task automatic test_reset_mid_div();
      int   n;
      logic seen;
      @(posedge clk_g); #1;
      bus8.func = 3'd7; bus8.num1 = 8'd200; bus8.num2 = 8'd7; bus8.button = 1'b1;
      n = 0;
      while (!bus8.busy && n < 12) begin @(negedge clk_g); n++; end
      checks += 1;
      if (!bus8.busy) begin errors++; $display("FAIL rstdiv_start: got busy=0 expected 1"); end
      repeat (2) @(negedge clk_g);
      rst = 1'b1; bus8.button = 1'b0;
      @(negedge clk_g);
      checks += 4;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy: got %b expected 0", bus8.busy); end
      if (bus8.cal_result !== 16'h0000) begin errors++; $display("FAIL rstdiv_result: got %h expected 0000", bus8.cal_result); end
      if (bus8.done !== 1'b0) begin errors++; $display("FAIL rstdiv_done: got %b expected 0", bus8.done); end
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin @(negedge clk_g); if (bus8.done || bus8.busy) seen = 1'b1; end
      if (seen !== 1'b0) begin errors++; $display("FAIL rstdiv_no_done: got activity=%b expected 0", seen); end
   endtask

   task automatic test_wide_mul();
      int          n;
      logic        got;
      logic [31:0] er, res;
      er = 32'(longint'(16'hFFFF) * longint'(16'h0002));
      got = 1'b0; res = 32'h0;
      @(posedge clk_g); #1;
      bus16.func = 3'd6; bus16.num1 = 16'hFFFF; bus16.num2 = 16'h0002; bus16.button = 1'b1;
      n = 0;
      while (!bus16.busy && n < 12) begin @(negedge clk_g); n++; end
      checks += 3;
      if (!bus16.busy) begin errors++; $display("FAIL w16_start: got busy=0 expected 1"); end
      bus16.func = 3'd0; bus16.num1 = 16'($urandom); bus16.num2 = 16'($urandom);
      n = 0;
      while (!got && n < 40) begin
         @(negedge clk_g); n++;
         if (bus16.done) begin got = 1'b1; res = bus16.cal_result; end
      end
      if (res !== er) begin errors++; $display("FAIL w16_result: got %h expected %h", res, er); end
      if (n !== 16) begin errors++; $display("FAIL w16_latency: got %0d expected 16", n); end
      bus16.button = 1'b0;
      repeat (5) @(negedge clk_g);
   endtask

   initial begin
      errors = 0; checks = 0;
      bus8.button = 1'b0; bus8.func = 3'd0; bus8.num1 = 8'h00; bus8.num2 = 8'h00;
      bus16.button = 1'b0; bus16.func = 3'd0; bus16.num1 = 16'h0; bus16.num2 = 16'h0;
      test_reset();
      test_directed();
      test_random();
      test_err_sticky();
      test_press_during_mul();
      test_reset_mid_div();
      test_wide_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
